// File: rtl/dmem_ctrl.sv
// Data-memory controller: word RAM with byte-lane stores, load extension and wait states.
// Optional misaligned-access trap: define DMEM_MISALIGN_TRAP_EN.
module dmem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        write,
    input  logic        mreq,
    input  logic [31:0] wr_data,
    input  logic [2:0]  funct3,
    output logic [31:0] rd_data,
    output logic        stall,
    output logic        done,
    output logic        fault
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [2:0] CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_reg, state_next;
    logic [2:0]      cnt_reg, cnt_next;
    logic [AW+1:0]   addr_reg;
    logic [31:0]     data_reg;
    logic [2:0]      f3_reg;
    logic            store_reg;

    logic            req;
    logic            enter_resp;
    logic            capture;

    logic [AW+1:0]   c_addr_raw, c_addr;
    logic [31:0]     c_data;
    logic [2:0]      c_f3;
    logic            c_store;
    logic            c_misalign;
    logic            trap;
    logic [AW-1:0]   c_idx;
    logic [3:0]      c_be;
    logic [31:0]     c_wdata;
    logic [31:0]     c_word;
    logic [7:0]      c_byte;
    logic [15:0]     c_half;
    logic [31:0]     c_load;
    logic            mem_we;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            unused_bits;
    assign unused_bits = ^{addr[31:AW+2], c_misalign};

    assign req     = write | mreq;
    assign capture = (state_reg == IDLE) && req;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stall      = 1'b0;
        enter_resp = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    stall = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_next = WAIT;
                        cnt_next   = CNT_INIT;
                    end else begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (cnt_reg == 3'd0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // With zero wait states the commit edge is also the capture edge, so use the live inputs.
    always_comb begin
        if (state_reg == IDLE) begin
            c_addr_raw = addr[AW+1:0];
            c_data     = wr_data;
            c_f3       = funct3;
            c_store    = write;
        end else begin
            c_addr_raw = addr_reg;
            c_data     = data_reg;
            c_f3       = f3_reg;
            c_store    = store_reg;
        end
    end

    assign c_misalign = ((c_f3[1:0] == 2'b01) && c_addr_raw[0]) ||
                        ((c_f3[1:0] == 2'b10) && (c_addr_raw[1:0] != 2'b00));

`ifdef DMEM_MISALIGN_TRAP_EN
    assign trap   = c_misalign;
    assign c_addr = c_addr_raw;
`else
    assign trap = 1'b0;
    always_comb begin
        case (c_f3[1:0])
            2'b01:   c_addr = {c_addr_raw[AW+1:1], 1'b0};
            2'b10:   c_addr = {c_addr_raw[AW+1:2], 2'b00};
            default: c_addr = c_addr_raw;
        endcase
    end
`endif

    assign c_idx = c_addr[AW+1:2];

    always_comb begin
        c_be    = 4'b0000;
        c_wdata = c_data;
        case (c_f3)
            3'b000: begin
                c_be    = 4'b0001 << c_addr[1:0];
                c_wdata = {4{c_data[7:0]}};
            end
            3'b001: begin
                c_be    = c_addr[1] ? 4'b1100 : 4'b0011;
                c_wdata = {2{c_data[15:0]}};
            end
            3'b010:  c_be = 4'b1111;
            default: c_be = 4'b0000;
        endcase
    end

    assign mem_we = enter_resp && c_store && !trap;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (c_be[i]) mem[c_idx][i*8 +: 8] <= c_wdata[i*8 +: 8];
            end
        end
    end

    assign c_word = mem[c_idx];
    assign c_byte = c_word[{c_addr[1:0], 3'b000} +: 8];
    assign c_half = c_addr[1] ? c_word[31:16] : c_word[15:0];

    always_comb begin
        case (c_f3)
            3'b000:  c_load = {{24{c_byte[7]}}, c_byte};
            3'b001:  c_load = {{16{c_half[15]}}, c_half};
            3'b010:  c_load = c_word;
            3'b100:  c_load = {24'd0, c_byte};
            3'b101:  c_load = {16'd0, c_half};
            default: c_load = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 3'd0;
            addr_reg  <= '0;
            data_reg  <= 32'd0;
            f3_reg    <= 3'd0;
            store_reg <= 1'b0;
            rd_data   <= 32'd0;
            done      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            done      <= enter_resp;
            fault     <= enter_resp && trap;
            if (capture) begin
                addr_reg  <= addr[AW+1:0];
                data_reg  <= wr_data;
                f3_reg    <= funct3;
                store_reg <= write;
            end
            if (enter_resp && (trap || !c_store)) begin
                rd_data <= trap ? 32'd0 : c_load;
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: vector table on a WAIT_STATES=1 instance plus timing/reset/misalign sequences.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wr_data;
    logic        write, mreq;
    logic [2:0]  funct3;
    logic [31:0] rd_data;
    logic        stall, done, fault;

    logic        mreq_b, mreq_c;
    logic [31:0] rd_data_b, rd_data_c;
    logic        stall_b, done_b, fault_b, stall_c, done_c, fault_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) dut (
        .clk(clk), .rst(rst), .addr(addr), .write(write), .mreq(mreq),
        .wr_data(wr_data), .funct3(funct3), .rd_data(rd_data),
        .stall(stall), .done(done), .fault(fault));

    dmem_ctrl #(.DEPTH_WORDS(16), .WAIT_STATES(2)) dut_b (
        .clk(clk), .rst(rst), .addr(addr), .write(1'b0), .mreq(mreq_b),
        .wr_data(32'h0), .funct3(funct3), .rd_data(rd_data_b),
        .stall(stall_b), .done(done_b), .fault(fault_b));

    dmem_ctrl #(.DEPTH_WORDS(16), .WAIT_STATES(0)) dut_c (
        .clk(clk), .rst(rst), .addr(addr), .write(1'b0), .mreq(mreq_c),
        .wr_data(32'h0), .funct3(funct3), .rd_data(rd_data_c),
        .stall(stall_c), .done(done_c), .fault(fault_c));

    typedef struct {
        logic        wr;
        logic        rd;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Called one time unit after a rising edge with the controller idle; returns the same way.
    task automatic run_access(input logic w, input logic m, input logic [2:0] f,
                              input logic [31:0] a, input logic [31:0] d,
                              output int scnt, output logic seen, output logic [31:0] r,
                              output logic flt, output logic done_after);
        write = w; mreq = m; funct3 = f; addr = a; wr_data = d;
        scnt = 0; seen = 1'b0; r = 32'h0; flt = 1'b0;
        #1;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (stall) scnt++;
            if (done) begin
                seen = 1'b1;
                r    = rd_data;
                flt  = fault;
            end else begin
                @(posedge clk); #1;
            end
        end
        write = 1'b0; mreq = 1'b0;
        @(posedge clk); #1;
        done_after = done;
    endtask

    task automatic access_chk(input string tag, input logic w, input logic m, input logic [2:0] f,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] exp_rd, input logic exp_fault);
        int          scnt;
        logic        seen, flt, da;
        logic [31:0] r;
        run_access(w, m, f, a, d, scnt, seen, r, flt, da);
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_stall_cycles"}, 32'(scnt), 32'd2);
        chk({tag, "_rd_data"}, r, exp_rd);
        chk({tag, "_fault"}, 32'(flt), 32'(exp_fault));
        chk({tag, "_done_single"}, 32'(da), 32'd0);
        $display("txn %s w=%0b r=%0b f3=%03b addr=%h wdata=%h rd_data=%h fault=%0b stall_cycles=%0d",
                 tag, w, m, f, a, d, r, flt, scnt);
    endtask

    initial begin
        logic [3:0] exp_stall_b, exp_done_b;

        vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h10,   32'hDEADBEEF, 32'h00000000};
        vecs[1]  = '{1'b0, 1'b1, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF};
        vecs[2]  = '{1'b1, 1'b0, 3'b010, 32'h20,   32'h0,        32'hDEADBEEF};
        vecs[3]  = '{1'b1, 1'b0, 3'b000, 32'h21,   32'h00000080, 32'hDEADBEEF};
        vecs[4]  = '{1'b0, 1'b1, 3'b100, 32'h21,   32'h0,        32'h00000080};
        vecs[5]  = '{1'b0, 1'b1, 3'b000, 32'h21,   32'h0,        32'hFFFFFF80};
        vecs[6]  = '{1'b0, 1'b1, 3'b010, 32'h20,   32'h0,        32'h00008000};
        vecs[7]  = '{1'b1, 1'b0, 3'b010, 32'h30,   32'h0,        32'h00008000};
        vecs[8]  = '{1'b1, 1'b0, 3'b001, 32'h32,   32'h00008001, 32'h00008000};
        vecs[9]  = '{1'b0, 1'b1, 3'b001, 32'h32,   32'h0,        32'hFFFF8001};
        vecs[10] = '{1'b0, 1'b1, 3'b101, 32'h32,   32'h0,        32'h00008001};
        vecs[11] = '{1'b0, 1'b1, 3'b010, 32'h30,   32'h0,        32'h80010000};
        vecs[12] = '{1'b1, 1'b1, 3'b010, 32'h50,   32'h11223344, 32'h80010000};
        vecs[13] = '{1'b0, 1'b1, 3'b010, 32'h50,   32'h0,        32'h11223344};
        vecs[14] = '{1'b0, 1'b1, 3'b010, 32'h1050, 32'h0,        32'h11223344};
        vecs[15] = '{1'b1, 1'b0, 3'b000, 32'h53,   32'h000000AB, 32'h11223344};
        vecs[16] = '{1'b0, 1'b1, 3'b010, 32'h50,   32'h0,        32'hAB223344};
        vecs[17] = '{1'b0, 1'b1, 3'b011, 32'h50,   32'h0,        32'h00000000};
        vecs[18] = '{1'b1, 1'b0, 3'b011, 32'h50,   32'hFFFFFFFF, 32'h00000000};
        vecs[19] = '{1'b0, 1'b1, 3'b001, 32'h52,   32'h0,        32'hFFFFAB22};
        vecs[20] = '{1'b0, 1'b1, 3'b000, 32'h50,   32'h0,        32'h00000044};
        vecs[21] = '{1'b1, 1'b0, 3'b010, 32'h40,   32'hA5A5A5A5, 32'h00000044};
        vecs[22] = '{1'b0, 1'b1, 3'b010, 32'h40,   32'h0,        32'hA5A5A5A5};

        rst = 1'b1; addr = 32'h0; wr_data = 32'h0; write = 1'b0; mreq = 1'b0;
        funct3 = 3'b010; mreq_b = 1'b0; mreq_c = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rd_data", rd_data, 32'h0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_fault", 32'(fault), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 23; i++) begin
            access_chk($sformatf("v%0d", i), vecs[i].wr, vecs[i].rd, vecs[i].f3,
                       vecs[i].a, vecs[i].d, vecs[i].exp, 1'b0);
        end

        // Two wait states, request held: stall for three cycles, done on the fourth, then idle.
        exp_stall_b = 4'b0111;
        exp_done_b  = 4'b1000;
        addr = 32'h4; funct3 = 3'b010; mreq_b = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("ws2_stall_c%0d", c), 32'(stall_b), 32'(exp_stall_b[c]));
            chk($sformatf("ws2_done_c%0d", c), 32'(done_b), 32'(exp_done_b[c]));
            if (c == 3) mreq_b = 1'b0;
            @(posedge clk); #1;
        end
        chk("ws2_idle_stall", 32'(stall_b), 32'd0);
        chk("ws2_idle_done", 32'(done_b), 32'd0);
        $display("txn ws2 lw addr=%h checked stall/done timing", addr);

        // Zero wait states: one stall cycle then the response.
        mreq_c = 1'b1;
        #1;
        chk("ws0_stall_c0", 32'(stall_c), 32'd1);
        chk("ws0_done_c0", 32'(done_c), 32'd0);
        @(posedge clk); #1;
        chk("ws0_stall_c1", 32'(stall_c), 32'd0);
        chk("ws0_done_c1", 32'(done_c), 32'd1);
        mreq_c = 1'b0;
        @(posedge clk); #1;
        chk("ws0_done_c2", 32'(done_c), 32'd0);
        $display("txn ws0 lw addr=%h checked stall/done timing", addr);

        // Reset while the store sits in WAIT: discarded, no done, rd_data cleared.
        write = 1'b1; funct3 = 3'b010; addr = 32'h40; wr_data = 32'h12345678;
        #1;
        chk("rstmid_stall_idle", 32'(stall), 32'd1);
        @(posedge clk); #1;
        chk("rstmid_stall_wait", 32'(stall), 32'd1);
        write = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstmid_stall", 32'(stall), 32'd0);
        chk("rstmid_rd_data", rd_data, 32'h0);
        chk("rstmid_done", 32'(done), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("rstmid_no_done_c%0d", c), 32'(done), 32'd0);
        end
        $display("txn reset during sw addr=40 checked discard");
        access_chk("rstmid_reload", 1'b0, 1'b1, 3'b010, 32'h40, 32'h0, 32'hA5A5A5A5, 1'b0);

        access_chk("mis_sw40", 1'b1, 1'b0, 3'b010, 32'h40, 32'hCAFEF00D, 32'hA5A5A5A5, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
        access_chk("mis_lw41", 1'b0, 1'b1, 3'b010, 32'h41, 32'h0, 32'h00000000, 1'b1);
        access_chk("mis_sw42", 1'b1, 1'b0, 3'b010, 32'h42, 32'h0BADBEEF, 32'h00000000, 1'b1);
        access_chk("mis_lw40", 1'b0, 1'b1, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0);
        access_chk("mis_lh43", 1'b0, 1'b1, 3'b001, 32'h43, 32'h0, 32'h00000000, 1'b1);
`else
        access_chk("mis_lw41", 1'b0, 1'b1, 3'b010, 32'h41, 32'h0, 32'hCAFEF00D, 1'b0);
        access_chk("mis_sw42", 1'b1, 1'b0, 3'b010, 32'h42, 32'h0BADBEEF, 32'hCAFEF00D, 1'b0);
        access_chk("mis_lw40", 1'b0, 1'b1, 3'b010, 32'h40, 32'h0, 32'h0BADBEEF, 1'b0);
        access_chk("mis_lh43", 1'b0, 1'b1, 3'b001, 32'h43, 32'h0, 32'h00000BAD, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller directly downstream of the MEM stage.
- Consumes the stage's addr/write/mreq/wr_data memory-side outputs, plus funct3 from the pipeline, and returns rd_data.
- Holds a word-organised RAM with byte-lane writes and load extension (lb/lh/lw/lbu/lhu, sb/sh/sw).
- Models configurable wait states; asserts a stall that freezes the pipeline until the access completes.

Parameters:
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two, minimum 4.
- WAIT_STATES, 1: extra access cycles, legal range 0..7.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- addr  in  32  byte address.
- write  in  1  store request.
- mreq  in  1  load request.
- wr_data  in  32  store data; the relevant bytes are in the low lanes.
- funct3  in  3  access size/sign, RV32I encoding.
- rd_data  out  32  extended load result.
- stall  out  1  pipeline hold.
- done  out  1  one-cycle completion pulse.
- fault  out  1  misaligned-access pulse; only meaningful with the optional feature.

Behaviour:
- Request: req = write | mreq. If both are high, the access is a store and rd_data is not updated.
- Addressing: word index = addr[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so accesses wrap modulo the RAM size.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on req, capture addr, wr_data, funct3 and op.
    - WAIT_STATES>0: go to WAIT and load counter = WAIT_STATES-1.
    - WAIT_STATES=0: go to RESP.
    - No req: stay in IDLE.
  - WAIT: decrement counter; on the clock edge where counter==0, go to RESP.
  - RESP: unconditionally return to IDLE; request inputs are not sampled in RESP.
- Commit: the RAM write or read happens on the edge that enters RESP, using only the captured values.
- stall = (IDLE & req) | WAIT, combinational.
  - Stall cycles per access = 1 + WAIT_STATES.
  - stall is 0 in RESP, so the pipeline advances at the end of the RESP cycle.
- done: registered; equals 1 exactly in the RESP cycle.
- Store byte enables (captured addr[1:0]):
  - sb (000): lane addr[1:0] receives wr_data[7:0].
  - sh (001): lanes {addr[1],0} and {addr[1],1} receive wr_data[15:0].
  - sw (010): all four lanes receive wr_data.
  - Other funct3 codes: no write.
- Load extension (registered into rd_data at commit):
  - lb (000): sign-extend the selected byte.
  - lh (001): sign-extend the selected halfword.
  - lw (010): the full word.
  - lbu (100): zero-extend the selected byte.
  - lhu (101): zero-extend the selected halfword.
  - Other codes: 0.
- rd_data holds its value until the next completed load.
- Reset values:
  - state = IDLE, counter = 0.
  - rd_data = 0, done = 0, fault = 0; stall is therefore 0 unless req is high.
  - RAM contents are not cleared.
- Reset mid-access: an uncommitted store is discarded and no done pulse follows. A store that entered RESP before reset is retained.
- Back-to-back requests: a new request is accepted only in IDLE, i.e. the cycle after RESP.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - Misalignment is detected at capture: halfword access with addr[0]=1, or word access with addr[1:0]!=0.
  - The access still runs the full FSM timing.
  - At commit: the store is suppressed, rd_data is set to 0, and fault pulses with done.
- Undefined:
  - Offending low address bits are forced to zero: addr[0] for halfwords, addr[1:0] for words.
  - The access proceeds as aligned.
  - fault is tied to 0.

Test Plan:
- sw 0xDEADBEEF @0x10, then lw @0x10 -> rd_data=0xDEADBEEF, with done pulsing once per access.
- sw 0 @0x20; sb 0x80 @0x21; lbu @0x21 -> 0x00000080; lb @0x21 -> 0xFFFFFF80; lw @0x20 -> 0x00008000.
- sh 0x8001 @0x32; lh @0x32 -> 0xFFFF8001; lhu @0x32 -> 0x00008001; lw @0x30 -> 0x80010000 (given the word was 0 before).
- WAIT_STATES=2, hold mreq -> stall high exactly 3 cycles, done high on the 4th cycle, IDLE on the 5th; WAIT_STATES=0 -> stall 1 cycle.
- Assert rst during WAIT of sw 0x12345678 @0x40 -> no done pulse, state IDLE, rd_data=0; lw @0x40 afterwards returns the prior contents.
- With DMEM_MISALIGN_TRAP_EN: lw @0x41 -> fault=1 and rd_data=0 in the done cycle, and the memory is unchanged. Without the macro: lw @0x41 -> returns the word @0x40 and fault=0.
